spm_ctrl: RTL and testbench
===========================

// Module: spm_ctrl
// PURPOSE
//  Command-driven sequencer for the 4-bank-group scratchpad. Accepts LOAD/RUN commands from the host.
//  LOAD streams host words into selected bank groups over ex_bus. RUN hands those groups to the
//  switch side (sel=1) for a counted number of cycles. Generates the scratchpad's 12-bit inst and
//  44-bit ex_bus; sits between the host/DMA interface and scratchpad.
// PARAMETERS
//  A_W    10  scratchpad word-address width (must match `A_W)
//  D_W    32  data word width
//  LEN_W  10  LOAD length field width (words)
//  RUN_W  16  RUN cycle-count field width
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      command accepted when valid&ready
//  cmd_op       in   2      00 LOAD, 01 RUN, 10 FILL (macro-gated), 11 reserved
//  cmd_bg_mask  in   4      target bank groups, bit i = BGi
//  cmd_mode     in   4      per-BG pattern bit, copied to inst[3:0] for masked BGs
//  cmd_addr     in   A_W    LOAD/FILL base word address
//  cmd_len      in   RUN_W  LOAD/FILL: word count (low LEN_W bits); RUN: cycle count
//  wr_valid     in   1      host data word offered (LOAD only)
//  wr_ready     out  1      host data word consumed when valid&ready
//  wr_data      in   D_W    host data word
//  inst         out  12     {en[11:8], sel[7:4], mode[3:0]} to scratchpad
//  ex_bus       out  44     {wen[43], ren[42], addr[41:32], data[31:0]} to scratchpad
//  busy         out  1      state != IDLE
//  done         out  1      one-cycle pulse on command completion
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; inst=0, ex_bus=0, busy=0, done=0, wr_ready=0, cmd_ready=0
//    while rst low. All counters cleared; any in-flight command is abandoned, no done pulse.
//  - FSM IDLE -> LOAD | RUN | FILL -> IDLE. cmd_ready = (state==IDLE) & rst high.
//  - Command fields are latched on acceptance. The original cmd_len is latched as the remaining
//    count; for LOAD/FILL only its low LEN_W bits are used.
//  - A zero count (LOAD/FILL: cmd_len[LEN_W-1:0]==0; RUN: cmd_len==0), mask==0, or op 11: the
//    command is accepted, no bus activity occurs, and done pulses the next cycle.
//  - LOAD, per cycle:
//    - wr_ready=1. On each wr handshake, the next cycle registers ex_bus={1,0,base+i,wr_data};
//      otherwise ex_wen=0.
//    - Latency: 1 cycle from handshake to ex_wen.
//    - Address increments modulo 2^A_W (wraps 1023->0).
//    - inst: en=mask, sel=0, mode=mask&cmd_mode.
//    - After the last word is accepted, wr_ready drops that cycle. The final ex_wen is seen the
//      next cycle, together with done=1. The state is IDLE in that same cycle, so a new command
//      can be accepted there.
//  - RUN:
//    - inst: en=mask, sel=mask, mode=mask&cmd_mode. ex_bus=0.
//    - Held for exactly cmd_len cycles.
//    - done pulses in the cycle inst returns to 0.
//  - IDLE: inst=0, ex_bus=0 (scratchpad quiescent).
//  - Unmasked BGs always have en=0, sel=0, mode=0.
//  - ex_ren is never asserted.
//  - wr_valid outside LOAD is ignored (wr_ready=0).
//  - A cmd_valid drop mid-command has no effect.
// CONFIGURATION
//  SPM_CTRL_FILL_EN defined:
//    - op 10 (FILL) writes D_W'h0 to len consecutive addresses, one per cycle, without using wr_*.
//    - Timing and inst are the same as LOAD with wr_valid held high.
//  SPM_CTRL_FILL_EN undefined:
//    - op 10 is treated like op 11: accepted, no bus activity, done pulses the next cycle.
// STRUCTURE
//  - Shared defines go in param_define.v:
//    - SPM_OP_LOAD/RUN/FILL encodings
//    - ex_bus field offsets (EXB_WEN=43, EXB_REN=42, EXB_ADDR_LSB=32)
//    - inst field offsets (INST_EN_LSB=8, INST_SEL_LSB=4)
//  - Local state encodings live in this file.
//  - One sub-module: spm_ctrl_cnt.
//    - Loadable down-counter with zero flag, shared by LOAD/FILL word count and RUN cycle count.
//    - A separate A_W-bit address incrementer stays inline.
// TESTING
//  1. LOAD mask=4'b0101 mode=4'b0001 addr=10'h3FE len=4; words A0..A3 back-to-back ->
//     ex_wen at addrs 3FE,3FF,000,001 with data A0..A3; inst=12'h501 throughout; done with last write.
//  2. LOAD len=3 with wr_valid toggling 1,0,1,0,1 -> exactly 3 writes, no ex_wen in gap cycles,
//     sequential addrs.
//  3. RUN mask=4'b1111 mode=4'b1010 len=5 -> inst=12'hFFA for exactly 5 cycles; then inst=0
//     with done=1; ex_bus=0 throughout.
//  4. LOAD len=0, then RUN mask=0 -> each: accepted, done the next cycle, no ex_wen, inst stays 0.
//  5. Assert rst low mid-LOAD (word 2 of 8) -> inst, ex_bus, busy drop to 0 immediately; no done;
//     after release, a new LOAD starts at its own base address.
//  6. With SPM_CTRL_FILL_EN: FILL addr=0 len=2 -> writes 0 to addrs 0 and 1 on consecutive cycles,
//     wr_ready=0. Without the macro: no writes, done the next cycle.

Source files
------------

// File: rtl/spm_ctrl_pkg.sv
// Shared encodings and bus field offsets for the scratchpad sequencer.
// Field offsets assume the default 10-bit address / 32-bit data scratchpad.
package spm_ctrl_pkg;

    localparam int unsigned SpmAW = 10;
    localparam int unsigned SpmDW = 32;

    localparam int unsigned ExbW       = 2 + SpmAW + SpmDW;
    localparam int unsigned ExbWen     = ExbW - 1;
    localparam int unsigned ExbRen     = ExbW - 2;
    localparam int unsigned ExbAddrLsb = SpmDW;

    localparam int unsigned InstEnLsb  = 8;
    localparam int unsigned InstSelLsb = 4;

    typedef enum logic [1:0] {
        OpLoad = 2'b00,
        OpRun  = 2'b01,
        OpFill = 2'b10,
        OpRsvd = 2'b11
    } spm_op_e;

endpackage

// File: rtl/spm_ctrl_cnt.sv
// Loadable down-counter with zero flag; shared by the word count and the RUN cycle count.
module spm_ctrl_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spm_ctrl.sv
// Command sequencer for the 4-bank-group scratchpad: LOAD streams host words, RUN hands groups
// to the switch side. Define SPM_CTRL_FILL_EN to enable the zero-fill command (op 10).
module spm_ctrl
    import spm_ctrl_pkg::*;
#(
    parameter int unsigned A_W   = SpmAW,
    parameter int unsigned D_W   = SpmDW,
    parameter int unsigned LEN_W = 10,
    parameter int unsigned RUN_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [3:0]         cmd_bg_mask_i,
    input  logic [3:0]         cmd_mode_i,
    input  logic [A_W-1:0]     cmd_addr_i,
    input  logic [RUN_W-1:0]   cmd_len_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [D_W-1:0]     wr_data_i,
    output logic [11:0]        inst_o,
    output logic [A_W+D_W+1:0] ex_bus_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StFill} state_e;

    state_e               state_q, state_d;
    logic [3:0]           mask_q, mask_d;
    logic [3:0]           mode_q, mode_d;
    logic [A_W-1:0]       addr_q, addr_d;
    logic [A_W+D_W+1:0]   ex_q, ex_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 go_words, go_run;
    logic [LEN_W-1:0]     len_lo;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [RUN_W-1:0]     cnt_load_val;

    assign cmd_ready_o = (state_q == StIdle) && rst_ni;
    assign wr_ready_o  = (state_q == StLoad);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign len_lo      = cmd_len_i[LEN_W-1:0];
    assign go_words    = (cmd_bg_mask_i != '0) && (len_lo != '0);
    assign go_run      = (cmd_bg_mask_i != '0) && (cmd_len_i != '0);

    // Counter holds remaining-minus-one so the zero flag marks the final beat.
    assign cnt_load_val = (spm_op_e'(cmd_op_i) == OpRun) ? cmd_len_i - 1'b1
                                                         : RUN_W'(len_lo) - 1'b1;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        ex_d     = '0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        inst_o   = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mask_d   = cmd_bg_mask_i;
                    mode_d   = cmd_bg_mask_i & cmd_mode_i;
                    addr_d   = cmd_addr_i;
                    cnt_load = 1'b1;
                    case (spm_op_e'(cmd_op_i))
                        OpLoad: begin
                            if (go_words) state_d = StLoad;
                            else          done_d  = 1'b1;
                        end
                        OpRun: begin
                            if (go_run) state_d = StRun;
                            else        done_d  = 1'b1;
                        end
                        OpFill: begin
`ifdef SPM_CTRL_FILL_EN
                            if (go_words) state_d = StFill;
                            else          done_d  = 1'b1;
`else
                            done_d = 1'b1;
`endif
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            StLoad, StFill: begin
                inst_o[InstEnLsb +: 4] = mask_q;
                inst_o[3:0]            = mode_q;
                if (state_q == StFill || wr_valid_i) begin
                    ex_d[ExbWen]              = 1'b1;
                    ex_d[ExbRen]              = 1'b0;
                    ex_d[ExbAddrLsb +: A_W]   = addr_q;
                    ex_d[D_W-1:0]             = (state_q == StFill) ? '0 : wr_data_i;
                    addr_d                    = addr_q + 1'b1;
                    if (cnt_zero) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            StRun: begin
                inst_o[InstEnLsb +: 4]  = mask_q;
                inst_o[InstSelLsb +: 4] = mask_q;
                inst_o[3:0]             = mode_q;
                if (cnt_zero) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            mask_q  <= '0;
            mode_q  <= '0;
            addr_q  <= '0;
            ex_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            ex_q    <= ex_d;
            done_q  <= done_d;
        end
    end

    spm_ctrl_cnt #(
        .Width (RUN_W)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign ex_bus_o = ex_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_spm_ctrl.sv
// Scoreboard bench for spm_ctrl: directed scenarios then random commands against a command-level
// model; a negedge monitor checks writes, inst, handshakes and done against queued expectations.
module tb_spm_ctrl;
    import spm_ctrl_pkg::*;

`ifdef SPM_CTRL_FILL_EN
    localparam bit FillEn = 1'b1;
`else
    localparam bit FillEn = 1'b0;
`endif

    typedef struct {
        logic [11:0] inst;
        int          cycles;     // busy cycles expected; -1 when host pacing decides
        int          writes;
        bit          last_wen;
        bit          is_load;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_mask = '0;
    logic [3:0]  cmd_mode = '0;
    logic [9:0]  cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic [11:0] inst;
    logic [43:0] ex_bus;
    logic        busy;
    logic        done;

    exp_t        cq[$];
    logic [41:0] wq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cur_w = 0;
    int          cur_c = 0;
    exp_t        me;
    logic [41:0] mw;

    always #5 clk = ~clk;

    spm_ctrl u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_bg_mask_i (cmd_mask),
        .cmd_mode_i    (cmd_mode),
        .cmd_addr_i    (cmd_addr),
        .cmd_len_i     (cmd_len),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_data_i     (wr_data),
        .inst_o        (inst),
        .ex_bus_o      (ex_bus),
        .busy_o        (busy),
        .done_o        (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got timeout, expected completion", name);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_inst"}, 64'(inst), 64'h0);
        check({tag, "_ex_bus"}, 64'(ex_bus), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_done"}, 64'(done), 64'h0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'h0);
        check({tag, "_wr_ready"}, 64'(wr_ready), 64'h0);
    endtask

    // Monitor: every cycle's outputs are matched against the expectation queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_w = 0;
            cur_c = 0;
        end else begin
            if (ex_bus[ExbWen]) begin
                if (wq.size() == 0) begin
                    check("ex_write_unexpected", 64'(ex_bus), 64'h0);
                end else begin
                    mw = wq.pop_front();
                    check("ex_write", 64'(ex_bus), 64'({2'b10, mw}));
                end
                cur_w++;
            end else begin
                check("ex_quiet", 64'(ex_bus), 64'h0);
            end
            if (busy) begin
                if (cq.size() == 0) begin
                    check("busy_unexpected", 64'(busy), 64'h0);
                end else begin
                    check("inst_busy", 64'(inst), 64'(cq[0].inst));
                    check("wr_ready_busy", 64'(wr_ready), 64'(cq[0].is_load));
                    check("cmd_ready_busy", 64'(cmd_ready), 64'h0);
                    cur_c++;
                end
            end else begin
                check("inst_idle", 64'(inst), 64'h0);
                check("wr_ready_idle", 64'(wr_ready), 64'h0);
                check("cmd_ready_idle", 64'(cmd_ready), 64'h1);
            end
            if (done) begin
                if (cq.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'h0);
                end else begin
                    me = cq.pop_front();
                    check("done_writes", 64'(cur_w), 64'(me.writes));
                    if (me.cycles >= 0) check("done_cycles", 64'(cur_c), 64'(me.cycles));
                    check("done_last_wen", 64'(ex_bus[ExbWen]), 64'(me.last_wen));
                end
                cur_w = 0;
                cur_c = 0;
            end
        end
    end

    // Issues one command: model pushes expectations, then the handshake and any host words.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] mode,
                           input logic [9:0] addr, input logic [15:0] len, input int gap,
                           input int feed_limit, input logic [31:0] dbase);
        exp_t        e;
        logic [31:0] wds[$];
        logic [31:0] d;
        logic [9:0]  a;
        int          eff;
        int          nfeed;
        int          i;
        int          t;
        bit          act;
        bit          ph;
        eff = (op == 2'b01) ? int'(len) : int'(len % 16'd1024);
        act = (mask != 4'h0) && (eff != 0) &&
              (op == 2'b00 || op == 2'b01 || (op == 2'b10 && FillEn));
        e.inst = '0; e.cycles = 0; e.writes = 0; e.last_wen = 1'b0;
        e.is_load = act && (op == 2'b00);
        if (act && op == 2'b01) begin
            e.inst   = {mask, mask, mask & mode};
            e.cycles = eff;
        end else if (act) begin
            e.inst     = {mask, 4'h0, mask & mode};
            e.writes   = eff;
            e.last_wen = 1'b1;
            e.cycles   = (op == 2'b00) ? -1 : eff;
            for (int k = 0; k < eff; k++) begin
                d = (op != 2'b00) ? 32'h0 : (dbase == 0) ? $urandom : dbase + 32'(k);
                a = addr + 10'(k);
                wds.push_back(d);
                wq.push_back({a, d});
            end
        end
        cq.push_back(e);

        @(negedge clk);
        wr_valid  = 1'b0;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_mode  = mode;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) timeout_fail("cmd_accept");
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_mask  = 4'($urandom);
        cmd_mode  = 4'($urandom);
        cmd_addr  = 10'($urandom);
        cmd_len   = 16'($urandom);

        if (e.is_load) begin
            nfeed = (feed_limit < 0) ? eff : feed_limit;
            i = 0; t = 0; ph = 1'b1;
            while (i < nfeed && t < 500) begin
                case (gap)
                    0:       wr_valid = 1'b1;
                    1:       wr_valid = ph;
                    default: wr_valid = ($urandom_range(0, 2) != 0);
                endcase
                ph = !ph;
                wr_data = wr_valid ? wds[i] : $urandom;
                if (wr_valid && wr_ready) i++;
                @(negedge clk);
                t++;
            end
            if (t >= 500) timeout_fail("wr_feed");
            wr_valid = 1'b0;
        end else begin
            // Stray host words outside LOAD must be ignored.
            wr_valid = 1'b1;
            wr_data  = $urandom;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((cq.size() != 0 || wq.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) timeout_fail("drain");
        wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [3:0]  mask;
        logic [15:0] len;
        logic [9:0]  addr;

        #1;
        check_quiet("reset");
        repeat (3) @(negedge clk);
        check_quiet("reset_held");
        rst_n = 1'b1;
        @(negedge clk);

        // Address wrap across 3FF with back-to-back words.
        run_cmd(2'b00, 4'b0101, 4'b0001, 10'h3FE, 16'd4, 0, -1, 32'hA0);
        wait_idle();
        // Alternating host valid.
        run_cmd(2'b00, 4'b0011, 4'b1111, 10'h010, 16'd3, 1, -1, 0);
        wait_idle();
        run_cmd(2'b01, 4'b1111, 4'b1010, 10'h000, 16'd5, 0, -1, 0);
        wait_idle();
        // Degenerate commands: zero length, empty mask.
        run_cmd(2'b00, 4'b0101, 4'b0101, 10'h020, 16'd0, 0, -1, 0);
        run_cmd(2'b01, 4'b0000, 4'b1111, 10'h000, 16'd5, 0, -1, 0);
        run_cmd(2'b11, 4'b1111, 4'b1111, 10'h000, 16'd5, 0, -1, 0);
        run_cmd(2'b00, 4'b1000, 4'b1000, 10'h030, 16'h0400, 0, -1, 0);
        wait_idle();
        run_cmd(2'b10, 4'b0001, 4'b0001, 10'h000, 16'd2, 0, -1, 0);
        wait_idle();

        // Reset in the middle of an 8-word LOAD.
        run_cmd(2'b00, 4'b0110, 4'b0010, 10'h100, 16'd8, 0, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("midload_reset");
        cq.delete();
        wq.delete();
        repeat (2) @(negedge clk);
        check_quiet("midload_reset_held");
        rst_n = 1'b1;
        run_cmd(2'b00, 4'b0110, 4'b0010, 10'h123, 16'd3, 0, -1, 0);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            op   = 2'($urandom_range(0, 3));
            mask = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            addr = ($urandom_range(0, 1) == 1) ? 10'h3FC + 10'($urandom_range(0, 3))
                                               : 10'($urandom);
            if (op == 2'b01) begin
                len = 16'($urandom_range(0, 12));
            end else begin
                len = 16'($urandom_range(0, 6));
                if ($urandom_range(0, 4) == 0) len = len | (16'h0400 << $urandom_range(0, 5));
            end
            run_cmd(op, mask, 4'($urandom), addr, len, 2, -1, 0);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
